spi_flash_reader: RTL and testbench

Read-only SPI master that fetches one 32-bit little-endian word per request from the external SPI flash on behalf of the CPU memory subsystem. Sits between the CPU-side memory request port and the flash pins (SPI_CS/SPI_SCK/SPI_SI/SPI_SO). It translates the 20-bit CPU address into the 24-bit flash address and issues a standard read command.

---
 rtl/spi_flash_reader.sv | 158 +++++++++++++++
 tb/tb_spi_flash_reader.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: fetches one little-endian 32-bit word per CPU request over SPI.
// Define SPI_FLASH_FASTREAD_EN for opcode 0x0B with 8 dummy clocks.
module spi_flash_reader #(
  parameter int          CLK_DIV      = 1,
  parameter logic [23:0] FLASH_OFFSET = 24'h050000,
  parameter logic [19:0] ADDR_LIMIT   = 20'hB0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [19:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        SPI_CS,
  output logic        SPI_SCK,
  output logic        SPI_SI,
  input  logic        SPI_SO
);

`ifdef SPI_FLASH_FASTREAD_EN
  localparam logic [7:0] OPCODE = 8'h0B;
  localparam int         NBITS  = 72;
  localparam int         DSTART = 40;
`else
  localparam logic [7:0] OPCODE = 8'h03;
  localparam int         NBITS  = 64;
  localparam int         DSTART = 32;
`endif

  localparam int            DW        = $clog2(2*CLK_DIV) + 1;
  localparam logic [DW-1:0] HALF_END  = DW'(CLK_DIV-1);
  localparam logic [DW-1:0] DESEL_END = DW'(2*CLK_DIV-1);
  localparam logic [6:0]    LAST_BIT  = 7'(NBITS-1);
  localparam logic [6:0]    DATA_BIT  = 7'(DSTART);
  localparam logic [6:0]    TX_BITS   = 7'd32;

  typedef enum logic [2:0] {
    IDLE,
    XFER,
    DONE,
    DESEL,
    ERR
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [6:0]    bit_q, bit_d;
  logic          sck_q, sck_d;
  logic [31:0]   tx_q, tx_d;
  logic [31:0]   rx_q, rx_d;
  logic [31:0]   data_q, data_d;

  logic [19:0] word_addr;
  logic [23:0] flash_addr;
  logic        accept;
  logic        in_range;
  logic        half_end;
  logic        bit_end;
  logic        last_bit;
  logic        unused_addr_bits;

  assign word_addr  = {req_addr[19:2], 2'b00};
  assign flash_addr = {4'b0, word_addr} + FLASH_OFFSET;
  assign in_range   = word_addr < ADDR_LIMIT;
  assign accept     = req_valid && (state_q == IDLE);
  assign half_end   = div_q == HALF_END;
  assign bit_end    = half_end && sck_q;
  assign last_bit   = bit_q == LAST_BIT;
  assign unused_addr_bits = ^req_addr[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sck_q   <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sck_q   <= sck_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = in_range ? XFER : ERR;
      XFER:    if (bit_end && last_bit) state_d = DONE;
      DONE:    state_d = DESEL;
      DESEL:   if (div_q == DESEL_END) state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_d  = '0;
    bit_d  = bit_q;
    sck_d  = 1'b0;
    tx_d   = tx_q;
    rx_d   = rx_q;
    data_d = data_q;
    unique case (state_q)
      IDLE: begin
        bit_d = '0;
        if (accept) begin
          tx_d   = {OPCODE, flash_addr};
          data_d = in_range ? data_q : '0;
        end
      end
      XFER: begin
        div_d = half_end ? '0 : div_q + 1'b1;
        sck_d = half_end ? ~sck_q : sck_q;
        // SO is captured on the edge that raises SCK
        if (half_end && !sck_q && bit_q >= DATA_BIT)
          rx_d = {rx_q[30:0], SPI_SO};
        if (bit_end) begin
          bit_d = bit_q + 1'b1;
          tx_d  = {tx_q[30:0], 1'b0};
        end
        if (bit_end && last_bit)
          data_d = {rx_q[7:0], rx_q[15:8],
                    rx_q[23:16], rx_q[31:24]};
      end
      DESEL:   div_d = div_q + 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
    SPI_CS    = 1'b1;
    SPI_SCK   = 1'b0;
    SPI_SI    = 1'b0;
    if (!reset) begin
      req_ready = state_q == IDLE;
      rsp_valid = (state_q == DONE) || (state_q == ERR);
      rsp_err   = state_q == ERR;
      rsp_data  = data_q;
      SPI_CS    = state_q != XFER;
      SPI_SCK   = sck_q;
      SPI_SI    = (state_q == XFER) && (bit_q < TX_BITS) && tx_q[31];
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader: randomized bench with a cycle-level reference model,
// a behavioural SPI flash, and a CLK_DIV=2 back-to-back instance.
`timescale 1ns/1ps
module tb_spi_flash_reader;

`ifdef SPI_FLASH_FASTREAD_EN
  localparam logic [7:0]  OPC     = 8'h0B;
  localparam int          NB      = 72;
  localparam int          DST     = 40;
  localparam int          LAT_LIT = 145;
  localparam logic [31:0] FRAME0  = 32'h0B050000;
  localparam int          B_GAP   = 294;
  localparam int          B_LAT   = 289;
`else
  localparam logic [7:0]  OPC     = 8'h03;
  localparam int          NB      = 64;
  localparam int          DST     = 32;
  localparam int          LAT_LIT = 129;
  localparam logic [31:0] FRAME0  = 32'h03050000;
  localparam int          B_GAP   = 262;
  localparam int          B_LAT   = 257;
`endif
  localparam int D    = 1;
  localparam int XCYC = 2*NB*D;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [19:0] req_addr = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic        cs, sck, si;
  logic        so = 1'b0;

  spi_flash_reader #(.CLK_DIV(1)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .SPI_CS(cs), .SPI_SCK(sck),
    .SPI_SI(si), .SPI_SO(so)
  );

  logic        b_reset = 1'b1;
  logic        b_req = 1'b0;
  logic [19:0] b_addr = 20'h00040;
  logic        b_ready, b_rsp, b_err, b_cs, b_sck, b_si;
  logic        b_so = 1'b0;
  logic [31:0] b_data;
  bit          b_done = 0;

  spi_flash_reader #(.CLK_DIV(2)) u_b2b (
    .clk(clk), .reset(b_reset),
    .req_valid(b_req), .req_ready(b_ready),
    .req_addr(b_addr),
    .rsp_valid(b_rsp), .rsp_data(b_data),
    .rsp_err(b_err),
    .SPI_CS(b_cs), .SPI_SCK(b_sck),
    .SPI_SI(b_si), .SPI_SO(b_so)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] fbyte(input logic [23:0] a);
    case (a)
      24'h050000: return 8'h13;
      24'h050001: return 8'h01;
      24'h050002: return 8'h10;
      24'h050003: return 8'h00;
      default:    return a[7:0] ^ a[15:8] ^ 8'h5A ^ {a[3:0], a[19:16]};
    endcase
  endfunction

  // behavioural flash: counts SCK rises, drives SO after each fall
  logic        prev_cs = 1'b1, prev_sck = 1'b0;
  int          nrise = 0;
  int          cs_low_cnt = 0;
  logic [31:0] frame = '0, cap_frame = '0;
  logic [23:0] cap_addr = '0;

  function automatic logic data_bit(input int k);
    logic [7:0] bb;
    int j;
    if (k < DST || k >= NB) return 1'($urandom_range(0, 1));
    j  = k - DST;
    bb = fbyte(cap_addr + 24'(j/8));
    return bb[7 - (j%8)];
  endfunction

  always @(negedge clk) begin
    if (!cs) cs_low_cnt++;
    if (!cs && prev_cs) nrise = 0;
    if (!cs && sck && !prev_sck) begin
      if (nrise < 32) frame = {frame[30:0], si};
      nrise++;
      if (nrise == 32) begin
        cap_frame = frame;
        cap_addr  = frame[23:0];
      end
    end
    if (!cs && !sck && prev_sck) so = data_bit(nrise);
    prev_cs  = cs;
    prev_sck = sck;
  end

  always @(negedge clk) b_so = 1'($urandom_range(0, 1));

  // reference model: per-request cycle arithmetic
  int          cyc = 0, ready_at = 0, acc_cyc = 0, n_acc = 0;
  int          t_start = 0, t_rsp = 0;
  logic        act = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_word = '0, exp_frame = '0, last_data = '0;
  logic [19:0] m_wa;
  logic [23:0] m_fa;

  always @(posedge clk) begin
    if (reset) begin
      act = 1'b0;
      ready_at = cyc + 1;
    end else if (req_valid && cyc >= ready_at) begin
      m_wa    = {req_addr[19:2], 2'b00};
      acc_cyc = cyc;
      n_acc++;
      act     = 1'b1;
      t_start = cyc + 1;
      if (m_wa >= 20'hB0000) begin
        exp_err  = 1'b1;
        exp_word = '0;
        t_rsp    = cyc + 1;
        ready_at = cyc + 2;
      end else begin
        m_fa      = {4'b0, m_wa} + 24'h050000;
        exp_err   = 1'b0;
        exp_frame = {OPC, m_fa};
        exp_word  = {fbyte(m_fa + 24'd3), fbyte(m_fa + 24'd2),
                     fbyte(m_fa + 24'd1), fbyte(m_fa)};
        t_rsp     = cyc + 1 + XCYC;
        ready_at  = t_rsp + 1 + 2*D;
      end
    end
    cyc++;
  end

  int n_dut_rsp = 0;
  always @(negedge clk) begin : cmp
    logic e_rdy, e_vld, e_err, e_cs, e_sck, e_si;
    int o, b;
    e_rdy = 1'b0; e_vld = 1'b0; e_err = 1'b0;
    e_cs = 1'b1; e_sck = 1'b0; e_si = 1'b0;
    if (rsp_valid) n_dut_rsp++;
    if (reset) begin
      last_data = '0;
    end else begin
      e_rdy = cyc >= ready_at;
      if (act && cyc >= t_start && cyc < t_rsp) begin
        o     = cyc - t_start;
        b     = o / (2*D);
        e_cs  = 1'b0;
        e_sck = (o % (2*D)) >= D;
        e_si  = (b < 32) ? exp_frame[31-b] : 1'b0;
      end
      if (act && cyc == t_rsp) begin
        e_vld     = 1'b1;
        e_err     = exp_err;
        last_data = exp_word;
      end
    end
    chk("cycle", {req_ready, rsp_valid, rsp_err, cs, sck, si, rsp_data},
        {e_rdy, e_vld, e_err, e_cs, e_sck, e_si, last_data});
  end

  task automatic send(input logic [19:0] a);
    int k;
    bit ok;
    k  = n_acc;
    ok = 0;
    req_addr  = a;
    req_valid = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (n_acc != k) ok = 1;
    end
    req_valid = 1'b0;
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_rsp(output logic [31:0] d, output logic e,
                          output int lat);
    bit ok;
    ok = 0; d = '0; e = 1'b0; lat = -1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok  = 1;
        d   = rsp_data;
        e   = rsp_err;
        lat = cyc - acc_cyc;
      end
    end
    if (!ok) chk("rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (cyc >= ready_at) ok = 1;
    end
    if (!ok) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin : b2b
    int acc[3];
    int nacc, rsp0, run, bc;
    acc = '{0, 0, 0};
    nacc = 0; rsp0 = -1; run = 0; bc = 0;
    b_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    b_reset = 1'b0;
    for (int i = 0; i < 3000 && nacc < 3; i++) begin
      @(negedge clk);
      bc++;
      if (b_ready) begin
        acc[nacc] = bc;
        nacc++;
      end
      if (b_rsp && rsp0 < 0) rsp0 = bc;
      if (b_cs) run++;
      else begin
        if (run > 0 && nacc >= 2) chk("b2b_cs_gap", 64'(run >= 4), 64'd1);
        run = 0;
      end
    end
    chk("b2b_accepts", 64'(nacc), 64'd3);
    chk("b2b_spacing1", 64'(acc[1] - acc[0]), 64'(B_GAP));
    chk("b2b_spacing2", 64'(acc[2] - acc[1]), 64'(B_GAP));
    chk("b2b_latency", 64'(rsp0 - acc[0]), 64'(B_LAT));
    b_done = 1;
  end

  initial begin : main
    logic [31:0] d;
    logic e;
    int lat, c0, n0, r;
    logic [19:0] a;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_pins", {cs, sck, si, rsp_valid, rsp_err, req_ready, rsp_data},
        {6'b100000, 32'h0});
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("ready_after_reset", 64'(req_ready), 64'd1);

    send(20'h00000);
    wait_rsp(d, e, lat);
    chk("basic_data", 64'(d), 64'h00100113);
    chk("basic_err", 64'(e), 64'd0);
    chk("basic_latency", 64'(lat), 64'(LAT_LIT));
    chk("basic_frame", 64'(cap_frame), 64'(FRAME0));
    wait_idle();

    send(20'hAFFFF);
    wait_rsp(d, e, lat);
    chk("xlate_top", 64'(cap_addr), 64'h0FFFFC);
    wait_idle();

    send(20'h00003);
    wait_rsp(d, e, lat);
    chk("xlate_align", 64'(cap_addr), 64'h050000);
    chk("align_data", 64'(d), 64'h00100113);
    wait_idle();

    c0 = cs_low_cnt;
    send(20'hB0000);
    wait_rsp(d, e, lat);
    chk("oor_latency", 64'(lat), 64'd1);
    chk("oor_err", 64'(e), 64'd1);
    chk("oor_data", 64'(d), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("oor_cs_idle", 64'(cs_low_cnt - c0), 64'd0);
    wait_idle();

    send(20'h00100);
    repeat (30) @(posedge clk);
    #1;
    n0 = n_dut_rsp;
    pulse_reset();
    chk("abort_pins", {62'd0, cs, sck}, 64'b10);
    repeat (200) @(posedge clk);
    #1;
    chk("abort_no_rsp", 64'(n_dut_rsp - n0), 64'd0);
    send(20'h00000);
    wait_rsp(d, e, lat);
    chk("after_abort_data", 64'(d), 64'h00100113);
    chk("after_abort_latency", 64'(lat), 64'(LAT_LIT));
    wait_idle();

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) a = 20'($urandom_range(20'hB0000, 20'hFFFFF));
      else a = 20'($urandom_range(0, 20'hAFFFF));
      send(a);
      r = $urandom_range(0, 7);
      if (r == 0) begin
        repeat ($urandom_range(1, XCYC - 2)) @(posedge clk);
        #1;
        pulse_reset();
      end else if (r > 2) begin
        wait_idle();
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #1;
      end
    end
    wait_idle();

    for (int i = 0; i < 3000 && !b_done; i++) @(posedge clk);
    if (!b_done) chk("b2b_timeout", 64'd0, 64'd1);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
